// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the iterative shift sequencer and its single-bit shifter stage.
// The shift codes are common to both, so they live here.
package shift_sequencer_pkg;

    localparam int SHIFTER_WIDTH = 32;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_SLL  = 2'b01;
    localparam logic [1:0] SH_SRL  = 2'b10;
    localparam logic [1:0] SH_SRA  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-bit shifter stage: moves the operand by exactly one position per use.
// SRA replicates bit 31; SLL and SRL fill with zero; SH_NONE passes through.
module shifter
    import shift_sequencer_pkg::*;
(
    input  logic [SHIFTER_WIDTH-1:0] in,
    input  logic [1:0]               shift,
    output logic [SHIFTER_WIDTH-1:0] sout
);

    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
        sout = in;
        case (shift)
            SH_SLL:  sout = {in[SHIFTER_WIDTH-2:0], 1'b0};
            SH_SRL:  sout = {1'b0, in[SHIFTER_WIDTH-1:1]};
            SH_SRA:  sout = {in[SHIFTER_WIDTH-1], in[SHIFTER_WIDTH-1:1]};
            default: sout = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLLI/SRLI/SRAI sequencer: iterates the one-bit shifter shamt times
// on an accumulator, with valid/ready handshakes toward issue and writeback.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         op_q;
    logic [1:0]         sh_code;
    logic [WIDTH-1:0]   sh_out;

    // Outside SHIFT the stage is held in pass-through so acc is never disturbed.
    assign sh_code = (state == SHIFT) ? op_q : SH_NONE;

    shifter u_shifter (
        .in    (acc),
        .shift (sh_code),
        .sout  (sh_out)
    );

    assign in_ready = (state == IDLE);
    assign out_data = acc;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments here so every register sees the pre-edge values of the others.
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            op_q      <= SH_NONE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc  <= in_data;
                        cnt  <= in_shamt;
                        op_q <= in_op;
                        busy <= 1'b1;
                        if (in_shamt == '0 || in_op == SH_NONE) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= sh_out;
                    cnt <= cnt - 1'b1;
                    // Leaving at cnt==1 means cnt never wraps below zero.
                    if (cnt == SHAMT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
